// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel-enable divider, h/v counters, registered
// sync/blank decode and line/frame strobes, all in the system clock domain.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       bright,
  output logic       hSync,
  output logic       vSync,
  output logic       pixel_tick,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [9:0]    H_MAX   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_MAX   = 10'(V_TOTAL - 1);

  // 11-bit bounds so an edge that lands exactly on 1024 still compares correctly
  localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div;
  logic          tick;
  logic [9:0]    h_nxt;
  logic [9:0]    v_nxt;

  function automatic logic in_range(input logic [9:0] x,
                                    input logic [10:0] lo,
                                    input logic [10:0] hi);
    return ({1'b0, x} >= lo) && ({1'b0, x} < hi);
  endfunction

  assign tick = (div == DIV_MAX);

  // Gated by the raw reset so the strobe drops immediately on async assertion
  assign pixel_tick = reset & tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_comb begin
    h_nxt = hCount;
    v_nxt = vCount;
    if (hCount == H_MAX) begin
      h_nxt = '0;
      v_nxt = (vCount == V_MAX) ? '0 : vCount + 10'd1;
    end else begin
      h_nxt = hCount + 10'd1;
    end
  end

  // Decode uses the next counter values so outputs line up with the counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hCount      <= '0;
      vCount      <= '0;
      bright      <= 1'b0;
      hSync       <= 1'b1;
      vSync       <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (tick) begin
      hCount      <= h_nxt;
      vCount      <= v_nxt;
      bright      <= in_range(h_nxt, '0, H_ACT) && in_range(v_nxt, '0, V_ACT);
      hSync       <= ~in_range(h_nxt, HS_BEG, HS_END);
      vSync       <= ~in_range(v_nxt, VS_BEG, VS_END);
      line_start  <= (h_nxt == '0);
      frame_start <= (h_nxt == '0) && (v_nxt == '0);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three instances (default, CLK_DIV=1,
// shrunken raster) compared every clock against a closed-form timing model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] hc;
    logic [9:0] vc;
    logic       br;
    logic       hs;
    logic       vs;
    logic       pt;
    logic       ls;
    logic       fs;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] a_hc, a_vc, b_hc, b_vc, c_hc, c_vc;
  logic a_br, a_hs, a_vs, a_pt, a_ls, a_fs;
  logic b_br, b_hs, b_vs, b_pt, b_ls, b_fs;
  logic c_br, c_hs, c_vs, c_pt, c_ls, c_fs;
  obs_t obs_a, obs_b, obs_c;

  vga_timing_gen #(.CLK_DIV(4)) u_a (
    .clk(clk), .reset(reset), .hCount(a_hc), .vCount(a_vc), .bright(a_br),
    .hSync(a_hs), .vSync(a_vs), .pixel_tick(a_pt), .line_start(a_ls),
    .frame_start(a_fs));

  vga_timing_gen #(.CLK_DIV(1)) u_b (
    .clk(clk), .reset(reset), .hCount(b_hc), .vCount(b_vc), .bright(b_br),
    .hSync(b_hs), .vSync(b_vs), .pixel_tick(b_pt), .line_start(b_ls),
    .frame_start(b_fs));

  vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                   .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)) u_c (
    .clk(clk), .reset(reset), .hCount(c_hc), .vCount(c_vc), .bright(c_br),
    .hSync(c_hs), .vSync(c_vs), .pixel_tick(c_pt), .line_start(c_ls),
    .frame_start(c_fs));

  assign obs_a = {a_hc, a_vc, a_br, a_hs, a_vs, a_pt, a_ls, a_fs};
  assign obs_b = {b_hc, b_vc, b_br, b_hs, b_vs, b_pt, b_ls, b_fs};
  assign obs_c = {c_hc, c_vc, c_br, c_hs, c_vs, c_pt, c_ls, c_fs};

  int total = 0;
  int bad = 0;
  int k = 0;
  obs_t q_a[$];
  obs_t q_b[$];
  obs_t q_c[$];
  int a_hs_low, a_ls_cnt, b_hs_low, b_ls_cnt, b_fs_cnt, c_vs_low, c_ls_cnt, c_fs_cnt;

  // Expected outputs after kk clock edges since reset release.
  function automatic obs_t model(int d, int ha, int hf, int hsw, int hb,
                                 int va, int vf, int vsw, int vb, int kk);
    obs_t o;
    int ht = ha + hf + hsw + hb;
    int vt = va + vf + vsw + vb;
    int n  = kk / d;
    int hc = n % ht;
    int vc = (n / ht) % vt;
    bit upd = ((kk % d) == 0) && (kk >= d);
    o.hc = 10'(hc);
    o.vc = 10'(vc);
    o.br = (n > 0) && (hc < ha) && (vc < va);
    o.hs = !((n > 0) && (hc >= ha + hf) && (hc < ha + hf + hsw));
    o.vs = !((n > 0) && (vc >= va + vf) && (vc < va + vf + vsw));
    o.pt = ((kk % d) == d - 1);
    o.ls = upd && (hc == 0);
    o.fs = upd && (hc == 0) && (vc == 0);
    return o;
  endfunction

  function automatic obs_t model_a(int kk);
    return model(4, 640, 16, 96, 48, 480, 10, 2, 33, kk);
  endfunction
  function automatic obs_t model_b(int kk);
    return model(1, 640, 16, 96, 48, 480, 10, 2, 33, kk);
  endfunction
  function automatic obs_t model_c(int kk);
    return model(2, 8, 2, 3, 2, 6, 1, 2, 2, kk);
  endfunction

  function automatic obs_t rst_obs();
    obs_t o;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    return o;
  endfunction

  task automatic chk(input string tag, input obs_t got, input obs_t exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s k=%0d got hc=%0d vc=%0d br/hs/vs/pt/ls/fs=%b%b%b%b%b%b exp hc=%0d vc=%0d br/hs/vs/pt/ls/fs=%b%b%b%b%b%b",
             tag, k, got.hc, got.vc, got.br, got.hs, got.vs, got.pt, got.ls, got.fs,
             exp.hc, exp.vc, exp.br, exp.hs, exp.vs, exp.pt, exp.ls, exp.fs);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    a_hs_low = 0; a_ls_cnt = 0; b_hs_low = 0; b_ls_cnt = 0; b_fs_cnt = 0;
    c_vs_low = 0; c_ls_cnt = 0; c_fs_cnt = 0;
  endtask

  // One clock: queue expectations, take the edge, pop and compare at negedge.
  task automatic cycle();
    if (reset) begin
      q_a.push_back(model_a(k + 1));
      q_b.push_back(model_b(k + 1));
      q_c.push_back(model_c(k + 1));
    end else begin
      q_a.push_back(rst_obs());
      q_b.push_back(rst_obs());
      q_c.push_back(rst_obs());
    end
    @(posedge clk);
    if (reset) k++;
    @(negedge clk);
    chk("a_cycle", obs_a, q_a.pop_front());
    chk("b_cycle", obs_b, q_b.pop_front());
    chk("c_cycle", obs_c, q_c.pop_front());
    if (!a_hs) a_hs_low++;
    if (a_ls) a_ls_cnt++;
    if (!b_hs) b_hs_low++;
    if (b_ls) b_ls_cnt++;
    if (b_fs) b_fs_cnt++;
    if (!c_vs) c_vs_low++;
    if (c_ls) c_ls_cnt++;
    if (c_fs) c_fs_cnt++;
  endtask

  // Window covers edges 1..3300 after release: one 3200-clk line of u_a,
  // four lines of u_b, exactly ten frames of u_c.
  task automatic run_window();
    clear_stats();
    repeat (3) cycle();
    chk_int("a_first_tick", int'(a_pt), 1);
    cycle();
    chk_int("a_first_hc", int'(a_hc), 1);
    repeat (3296) cycle();
    chk_int("a_hsync_low_clks", a_hs_low, 384);
    chk_int("a_line_starts", a_ls_cnt, 1);
    chk_int("b_hsync_low_clks", b_hs_low, 384);
    chk_int("b_line_starts", b_ls_cnt, 4);
    chk_int("b_frame_starts", b_fs_cnt, 0);
    chk_int("c_vsync_low_clks", c_vs_low, 600);
    chk_int("c_line_starts", c_ls_cnt, 110);
    chk_int("c_frame_starts", c_fs_cnt, 10);
  endtask

  initial begin
    bit found;
    obs_t m;
    reset = 1'b0;
    repeat (20) cycle();

    reset = 1'b1;
    k = 0;
    run_window();

    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      m = model_c(k);
      if (m.hc >= 10 && m.hc <= 12 && m.vc >= 7 && m.vc <= 8) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    chk_int("c_reach_sync_region", int'(found), 1);
    chk_int("c_hsync_before_rst", int'(c_hs), 0);
    chk_int("c_vsync_before_rst", int'(c_vs), 0);

    #2 reset = 1'b0;
    #1;
    chk("a_async_rst", obs_a, rst_obs());
    chk("b_async_rst", obs_b, rst_obs());
    chk("c_async_rst", obs_c, rst_obs());
    k = 0;
    repeat (5) cycle();

    reset = 1'b1;
    run_window();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
